uart_text_tx: RTL and testbench

- Transmit side of the UART text path: holds one 16-character text row and sends it out as 8N1 UART frames on a single serial line.
- The display/control logic writes characters by index and pulses `start`; the block serializes characters 0..NUM_CHARS-1 in order, then reports `done`.
- It is the counterpart of the UART-to-text-row receiver and pairs with the same host terminal.

---
 rtl/uart_text_pkg.sv | 31 +++
 rtl/uart_tx_frame.sv | 99 +++++++++
 rtl/uart_text_tx.sv | 137 +++++++++++++
 tb/tb_uart_text_tx.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_text_pkg.sv
// Shared types and constants for the UART text-row transmitter.
// Optional CR/LF terminator frames are enabled with macro UART_TEXT_TX_CRLF_EN.
package uart_text_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START_BIT = 3'd2,
        ST_DATA_BITS = 3'd3,
        ST_STOP_BIT  = 3'd4,
        ST_NEXT_CHAR = 3'd5
    } state_t;

    localparam int DEFAULT_DELAY_FRAMES = 234;
    localparam int DEFAULT_NUM_CHARS    = 16;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

`ifdef UART_TEXT_TX_CRLF_EN
    localparam int TERM_CHARS = 2;
`else
    localparam int TERM_CHARS = 0;
`endif

    function automatic int total_slots(input int num_chars);
        return num_chars + TERM_CHARS;
    endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// 8N1 serializer: one start bit, eight data bits LSB first, one stop bit,
// each held for DELAY_FRAMES clocks. The line register lags the phase by one clock.
module uart_tx_frame
    import uart_text_pkg::*;
#(
    parameter int DELAY_FRAMES = DEFAULT_DELAY_FRAMES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       busy,
    output logic       frame_done,
    output logic       uart_tx
);
    localparam int CNT_W = (DELAY_FRAMES > 1) ? $clog2(DELAY_FRAMES) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DELAY_FRAMES - 1);

    state_t            state_r;
    state_t            next_state_s;
    logic [CNT_W-1:0]  baud_cnt_r;
    logic [2:0]        bit_idx_r;
    logic [7:0]        shift_r;
    logic              tx_r;
    logic              baud_last_s;
    logic              frame_done_s;

    // Phase sequencing and end-of-frame strobe
    always_comb begin
        next_state_s = state_r;
        frame_done_s = 1'b0;
        baud_last_s  = (baud_cnt_r == BAUD_LAST);
        case (state_r)
            ST_IDLE: begin
                if (load) next_state_s = ST_START_BIT;
                else      next_state_s = ST_IDLE;
            end
            ST_START_BIT: begin
                if (baud_last_s) next_state_s = ST_DATA_BITS;
                else             next_state_s = ST_START_BIT;
            end
            ST_DATA_BITS: begin
                if (baud_last_s && (bit_idx_r == 3'd7)) next_state_s = ST_STOP_BIT;
                else                                     next_state_s = ST_DATA_BITS;
            end
            ST_STOP_BIT: begin
                if (baud_last_s) begin
                    next_state_s = ST_IDLE;
                    frame_done_s = 1'b1;
                end else begin
                    next_state_s = ST_STOP_BIT;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Phase register, baud/bit counters and the byte being shifted out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= CNT_W'(0);
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
        end else begin
            state_r <= next_state_s;
            if (state_r == ST_IDLE) begin
                baud_cnt_r <= CNT_W'(0);
                bit_idx_r  <= 3'd0;
                if (load) shift_r <= data;
            end else begin
                baud_cnt_r <= baud_last_s ? CNT_W'(0) : baud_cnt_r + CNT_W'(1);
                if (state_r == ST_START_BIT) begin
                    bit_idx_r <= 3'd0;
                end else if ((state_r == ST_DATA_BITS) && baud_last_s) begin
                    bit_idx_r <= bit_idx_r + 3'd1;
                end
            end
        end
    end

    // Registered line level; anything but start/data phases keeps the line high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_r <= 1'b1;
        end else begin
            case (state_r)
                ST_START_BIT: tx_r <= 1'b0;
                ST_DATA_BITS: tx_r <= shift_r[bit_idx_r];
                default:      tx_r <= 1'b1;
            endcase
        end
    end

    assign busy       = (state_r != ST_IDLE);
    assign frame_done = frame_done_s;
    assign uart_tx    = tx_r;

endmodule

// File: rtl/uart_text_tx.sv
// Text-row UART transmitter: a NUM_CHARS byte buffer sent as 8N1 frames on start.
// Defining UART_TEXT_TX_CRLF_EN appends CR and LF frames after the last character.
module uart_text_tx
    import uart_text_pkg::*;
#(
    parameter int DELAY_FRAMES = DEFAULT_DELAY_FRAMES,
    parameter int NUM_CHARS    = DEFAULT_NUM_CHARS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [$clog2(NUM_CHARS)-1:0] wr_index,
    input  logic [7:0]                   wr_data,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         uart_tx
);
    localparam int WI_W  = $clog2(NUM_CHARS);
    localparam int SLOTS = total_slots(NUM_CHARS);
    localparam int IDX_W = $clog2(SLOTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOTS - 1);

    // ST_START_BIT here covers the whole frame window; the serializer owns its sub-phases.
    state_t           state_r;
    state_t           next_state_s;
    logic [IDX_W-1:0] char_idx_r;
    logic [7:0]       text_r [NUM_CHARS];
    logic [7:0]       load_byte_s;
    logic             busy_r;
    logic             done_r;
    logic             frame_load_s;
    logic             frame_busy_s;
    logic             frame_done_s;
    logic             last_char_s;

    // Byte handed to the serializer for the current slot
    always_comb begin
        load_byte_s = ASCII_SPACE;
`ifdef UART_TEXT_TX_CRLF_EN
        if (char_idx_r == IDX_W'(NUM_CHARS)) begin
            load_byte_s = ASCII_CR;
        end else if (char_idx_r == IDX_W'(NUM_CHARS + 1)) begin
            load_byte_s = ASCII_LF;
        end else begin
            load_byte_s = text_r[char_idx_r[WI_W-1:0]];
        end
`else
        load_byte_s = text_r[char_idx_r];
`endif
    end

    // Row sequencing across slots
    always_comb begin
        next_state_s = state_r;
        frame_load_s = 1'b0;
        last_char_s  = (char_idx_r == LAST_IDX);
        case (state_r)
            ST_IDLE: begin
                if (start) next_state_s = ST_LOAD;
                else       next_state_s = ST_IDLE;
            end
            ST_LOAD: begin
                frame_load_s = 1'b1;
                next_state_s = ST_START_BIT;
            end
            ST_START_BIT: begin
                if (frame_done_s)       next_state_s = ST_NEXT_CHAR;
                else if (!frame_busy_s) next_state_s = ST_IDLE;
                else                    next_state_s = ST_START_BIT;
            end
            ST_NEXT_CHAR: begin
                if (last_char_s) next_state_s = ST_IDLE;
                else             next_state_s = ST_LOAD;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State, slot index and the registered busy/done outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            char_idx_r <= IDX_W'(0);
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r <= next_state_s;
            done_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        char_idx_r <= IDX_W'(0);
                        busy_r     <= 1'b1;
                    end
                end
                ST_START_BIT: begin
                    if (!frame_done_s && !frame_busy_s) busy_r <= 1'b0;
                end
                ST_NEXT_CHAR: begin
                    if (last_char_s) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end else begin
                        char_idx_r <= char_idx_r + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Character buffer; writes only land while idle so a row in flight is stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CHARS; i++) text_r[i] <= ASCII_SPACE;
        end else if (wr_en && (state_r == ST_IDLE)) begin
            text_r[wr_index] <= wr_data;
        end
    end

    uart_tx_frame #(
        .DELAY_FRAMES(DELAY_FRAMES)
    ) u_frame (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (frame_load_s),
        .data      (load_byte_s),
        .busy      (frame_busy_s),
        .frame_done(frame_done_s),
        .uart_tx   (uart_tx)
    );

    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_uart_text_tx.sv
// Self-checking bench for uart_text_tx: a line-level UART decoder and a row model.
module tb_uart_text_tx;
    localparam int D  = 4;
    localparam int NC = 16;
`ifdef UART_TEXT_TX_CRLF_EN
    localparam int TOTAL = NC + 2;
`else
    localparam int TOTAL = NC;
`endif
    localparam int FRAME_CYC = 10 * D + 2;
    localparam int ROW_CYC   = TOTAL * FRAME_CYC;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [3:0] wr_index;
    logic [7:0] wr_data;
    logic       start;
    logic       busy;
    logic       done;
    logic       uart_tx;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] model_row [NC];

    // line decoder / monitor state (written only by the monitor process)
    int         done_cnt   = 0;
    int         busy_err   = 0;
    int         glitch_cnt = 0;
    int         frame_err  = 0;
    bit         mon_active = 1'b0;
    int         mon_pos    = 0;
    logic       cur_bit    = 1'b1;
    logic       prev_busy  = 1'b0;
    logic [7:0] sh         = 8'h00;
    logic [7:0] byte_q [$];
    time        ftime_q [$];
    time        done_time  = 0;

    uart_text_tx #(.DELAY_FRAMES(D), .NUM_CHARS(NC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_index(wr_index),
        .wr_data (wr_data),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    // Decode frames from the line on the falling clock edge, every bit is D samples
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_active = 1'b0;
            prev_busy  = 1'b0;
        end else begin
            if (done === 1'b1) begin
                done_cnt++;
                done_time = $time;
                if (busy !== 1'b0 || prev_busy !== 1'b1) busy_err++;
            end
            prev_busy = busy;
            if (!mon_active) begin
                if (uart_tx === 1'b0) begin
                    mon_active = 1'b1;
                    mon_pos    = 0;
                    ftime_q.push_back($time);
                end
            end else begin
                mon_pos++;
            end
            if (mon_active) begin
                if (mon_pos % D == 0) cur_bit = uart_tx;
                else if (uart_tx !== cur_bit) glitch_cnt++;
                if (mon_pos % D == D / 2) begin
                    if (mon_pos / D == 0 && uart_tx !== 1'b0) frame_err++;
                    if (mon_pos / D >= 1 && mon_pos / D <= 8) sh[mon_pos / D - 1] = uart_tx;
                    if (mon_pos / D == 9 && uart_tx !== 1'b1) frame_err++;
                end
                if (mon_pos == 10 * D - 1) begin
                    byte_q.push_back(sh);
                    mon_active = 1'b0;
                end
            end
        end
    end

    function automatic logic [7:0] exp_frame(input int i);
        if (i < NC)       return model_row[i];
        else if (i == NC) return 8'h0D;
        else              return 8'h0A;
    endfunction

    task automatic kick(output time t0);
        @(negedge clk); start = 1'b1;
        @(posedge clk); t0 = $time;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(posedge clk);
            if (done_cnt > base) ok = 1'b1;
        end
    endtask

    task automatic write_slot(input int idx, input logic [7:0] d);
        @(negedge clk); wr_en = 1'b1; wr_index = idx[3:0]; wr_data = d;
        @(negedge clk); wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; wr_en = 1'b0; wr_index = 4'd0; wr_data = 8'h00;
        for (int i = 0; i < NC; i++) model_row[i] = 8'h20;
        #12;
        n_tests++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", uart_tx); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++; if (uart_tx !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle: got tx=%b busy=%b want tx=1 busy=0", uart_tx, busy);
        end
    endtask

    task automatic test_default_row();
        time t0; bit ok; int bad; longint lat;
        int fb = byte_q.size(); int tb0 = ftime_q.size(); int db = done_cnt;
        int be = busy_err; int ge = glitch_cnt; int fe = frame_err;
        kick(t0);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: got %b want 1", busy); end
        wait_done(db, ROW_CYC + 100, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL default_done_timeout: got no done want done within %0d", ROW_CYC + 100); end
        repeat (5) @(posedge clk);
        n_tests++; if (byte_q.size() - fb != TOTAL) begin
            n_fail++; $display("FAIL default_frame_count: got %0d want %0d", byte_q.size() - fb, TOTAL);
        end
        for (int i = 0; i < TOTAL && fb + i < byte_q.size(); i++) begin
            n_tests++; if (byte_q[fb + i] !== exp_frame(i)) begin
                n_fail++; $display("FAIL default_byte[%0d]: got %h want %h", i, byte_q[fb + i], exp_frame(i));
            end
        end
        lat = longint'((done_time - t0 - 5) / 10);
        n_tests++; if (lat != ROW_CYC) begin n_fail++; $display("FAIL done_latency: got %0d want %0d", lat, ROW_CYC); end
        if (ftime_q.size() > tb0) begin
            lat = longint'((ftime_q[tb0] - t0 - 5) / 10);
            n_tests++; if (lat != 2) begin n_fail++; $display("FAIL first_fall_latency: got %0d want 2", lat); end
        end
        bad = 0;
        for (int i = 1; i < TOTAL && tb0 + i < ftime_q.size(); i++)
            if (ftime_q[tb0 + i] - ftime_q[tb0 + i - 1] != time'(FRAME_CYC * 10)) bad++;
        n_tests++; if (bad != 0) begin n_fail++; $display("FAIL frame_spacing: got %0d bad gaps want 0", bad); end
        n_tests++; if (done_cnt - db != 1) begin n_fail++; $display("FAIL default_done_count: got %0d want 1", done_cnt - db); end
        n_tests++; if (busy_err != be) begin n_fail++; $display("FAIL busy_with_done: got %0d errors want 0", busy_err - be); end
        n_tests++; if (glitch_cnt != ge || frame_err != fe) begin
            n_fail++; $display("FAIL framing: got glitch=%0d ferr=%0d want 0 0", glitch_cnt - ge, frame_err - fe);
        end
    endtask

    task automatic test_hello();
        time t0; bit ok;
        logic [7:0] hello [5];
        int fb; int db; int fe;
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        for (int i = 0; i < 5; i++) begin write_slot(i, hello[i]); model_row[i] = hello[i]; end
        fb = byte_q.size(); db = done_cnt; fe = frame_err;
        kick(t0);
        wait_done(db, ROW_CYC + 100, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL hello_done_timeout: got no done want done"); end
        repeat (5) @(posedge clk);
        n_tests++; if (byte_q.size() - fb != TOTAL) begin
            n_fail++; $display("FAIL hello_frame_count: got %0d want %0d", byte_q.size() - fb, TOTAL);
        end
        for (int i = 0; i < TOTAL && fb + i < byte_q.size(); i++) begin
            n_tests++; if (byte_q[fb + i] !== exp_frame(i)) begin
                n_fail++; $display("FAIL hello_byte[%0d]: got %h want %h", i, byte_q[fb + i], exp_frame(i));
            end
        end
        n_tests++; if (frame_err != fe) begin n_fail++; $display("FAIL hello_start_stop: got %0d errors want 0", frame_err - fe); end
    endtask

    task automatic test_write_during_tx();
        time t0; bit ok; int fb; int db;
        for (int pass = 0; pass < 2; pass++) begin
            fb = byte_q.size(); db = done_cnt;
            kick(t0);
            if (pass == 0) begin
                repeat (9) @(negedge clk);
                wr_en = 1'b1; wr_index = 4'd3; wr_data = 8'h41;
                @(negedge clk); wr_en = 1'b0;
            end
            wait_done(db, ROW_CYC + 100, ok);
            n_tests++; if (!ok) begin n_fail++; $display("FAIL busy_write_done_timeout: pass %0d got no done", pass); end
            repeat (5) @(posedge clk);
            n_tests++; if (byte_q.size() - fb != TOTAL) begin
                n_fail++; $display("FAIL busy_write_count: pass %0d got %0d want %0d", pass, byte_q.size() - fb, TOTAL);
            end
            if (byte_q.size() > fb + 3) begin
                n_tests++; if (byte_q[fb + 3] !== model_row[3]) begin
                    n_fail++; $display("FAIL busy_write_slot3: pass %0d got %h want %h", pass, byte_q[fb + 3], model_row[3]);
                end
            end
        end
    endtask

    task automatic test_start_ignored();
        time t0; bit ok; int fb = byte_q.size(); int db = done_cnt;
        int gap = $urandom_range(50, ROW_CYC - 50);
        kick(t0);
        repeat (gap) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_done(db, ROW_CYC + 100, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL restart_done_timeout: got no done want done"); end
        repeat (100) @(posedge clk);
        n_tests++; if (byte_q.size() - fb != TOTAL) begin
            n_fail++; $display("FAIL restart_frame_count: got %0d want %0d", byte_q.size() - fb, TOTAL);
        end
        n_tests++; if (done_cnt - db != 1) begin n_fail++; $display("FAIL restart_done_count: got %0d want 1", done_cnt - db); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_busy_idle: got %b want 0", busy); end
    endtask

    task automatic test_random_row();
        time t0; bit ok; int fb; int db; int idx; logic [7:0] d;
        for (int k = 0; k < 6; k++) begin
            idx = $urandom_range(0, NC - 1);
            d   = 8'($urandom_range(33, 126));
            write_slot(idx, d);
            model_row[idx] = d;
        end
        fb = byte_q.size(); db = done_cnt;
        idx = $urandom_range(0, NC - 1);
        d   = 8'($urandom_range(33, 126));
        @(negedge clk);
        wr_en = 1'b1; wr_index = idx[3:0]; wr_data = d; start = 1'b1;
        model_row[idx] = d;
        @(posedge clk); t0 = $time;
        @(negedge clk); wr_en = 1'b0; start = 1'b0;
        wait_done(db, ROW_CYC + 100, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL random_done_timeout: got no done want done"); end
        repeat (5) @(posedge clk);
        n_tests++; if (byte_q.size() - fb != TOTAL) begin
            n_fail++; $display("FAIL random_frame_count: got %0d want %0d", byte_q.size() - fb, TOTAL);
        end
        for (int i = 0; i < TOTAL && fb + i < byte_q.size(); i++) begin
            n_tests++; if (byte_q[fb + i] !== exp_frame(i)) begin
                n_fail++; $display("FAIL random_byte[%0d]: got %h want %h", i, byte_q[fb + i], exp_frame(i));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        time t0; bit ok; int fb; int db; int tb0 = ftime_q.size();
        db = done_cnt;
        kick(t0);
        ok = 1'b0;
        for (int i = 0; i < 6 * FRAME_CYC + 20 && !ok; i++) begin
            @(posedge clk);
            if (ftime_q.size() >= tb0 + 6) ok = 1'b1;
        end
        n_tests++; if (!ok) begin n_fail++; $display("FAIL abort_reach_char5: got %0d frames want 6 started", ftime_q.size() - tb0); end
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (uart_tx !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_async: got tx=%b busy=%b want tx=1 busy=0", uart_tx, busy);
        end
        for (int i = 0; i < NC; i++) model_row[i] = 8'h20;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        n_tests++; if (done_cnt != db) begin n_fail++; $display("FAIL abort_no_done: got %0d dones want 0", done_cnt - db); end
        fb = byte_q.size(); db = done_cnt;
        kick(t0);
        wait_done(db, ROW_CYC + 100, ok);
        n_tests++; if (!ok) begin n_fail++; $display("FAIL abort_rerun_timeout: got no done want done"); end
        repeat (5) @(posedge clk);
        n_tests++; if (byte_q.size() - fb != TOTAL) begin
            n_fail++; $display("FAIL abort_rerun_count: got %0d want %0d", byte_q.size() - fb, TOTAL);
        end
        for (int i = 0; i < TOTAL && fb + i < byte_q.size(); i++) begin
            n_tests++; if (byte_q[fb + i] !== exp_frame(i)) begin
                n_fail++; $display("FAIL abort_rerun_byte[%0d]: got %h want %h", i, byte_q[fb + i], exp_frame(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_row();
        test_hello();
        test_write_during_tx();
        test_start_ignored();
        test_random_row();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
